// File: rtl/conv5_mac_if.sv
// Bus bundle for the five-tap MAC: window words, coefficient port, run/status.
interface conv5_mac_if #(
   parameter int DataSize = 32,
   parameter int CoefSize = 16
) ();
   logic                start;
   logic [DataSize-1:0] src1, src2, src3, src4, src5;
   logic                coef_wr;
   logic [2:0]          coef_addr;
   logic [CoefSize-1:0] coef_data;
   logic                busy;
   logic                out_valid;
   logic [DataSize-1:0] result;
   logic                sat;

   modport master (
      output start, src1, src2, src3, src4, src5, coef_wr, coef_addr, coef_data,
      input  busy, out_valid, result, sat
   );

   modport slave (
      input  start, src1, src2, src3, src4, src5, coef_wr, coef_addr, coef_data,
      output busy, out_valid, result, sat
   );
endinterface

// File: rtl/conv5_mac.sv
// Five-tap signed MAC: captures a window on start, accumulates one tap per
// cycle at full precision, then shifts, saturates and presents the result.
module conv5_mac #(
   parameter int DataSize = 32,
   parameter int CoefSize = 16,
   parameter int Shift    = 0
) (
   input  logic       clk,
   input  logic       rst,
   conv5_mac_if.slave bus
);
   localparam int AccSize  = DataSize + CoefSize + 3;
   localparam int ProdSize = DataSize + CoefSize;

   // Signed result range expressed at accumulator width for the clip compare.
   localparam logic signed [AccSize-1:0] SatMax =
      {{(AccSize-DataSize+1){1'b0}}, {(DataSize-1){1'b1}}};
   localparam logic signed [AccSize-1:0] SatMin =
      {{(AccSize-DataSize+1){1'b1}}, {(DataSize-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

   state_t                     state, state_nxt;
   logic [2:0]                 cnt;
   logic signed [AccSize-1:0]  acc, acc_nxt, scaled;
   logic [DataSize-1:0]        w    [5];
   logic [CoefSize-1:0]        coef [5];
   logic signed [DataSize-1:0] tap_w;
   logic signed [CoefSize-1:0] tap_c;
   logic signed [ProdSize-1:0] prod;
   logic [DataSize-1:0]        result_q, sat_res;
   logic                       sat_q, sat_nxt;

   assign bus.busy      = (state != IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.result    = result_q;
   assign bus.sat       = sat_q;

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // Next state: start only matters in IDLE; DONE always falls back to IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = MAC;
         MAC:     if (cnt == 3'd4) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Tap select by counter; explicit mux keeps unused counter codes harmless.
   always_comb begin
      tap_w = '0;
      tap_c = '0;
      case (cnt)
         3'd0: begin tap_w = w[0]; tap_c = coef[0]; end
         3'd1: begin tap_w = w[1]; tap_c = coef[1]; end
         3'd2: begin tap_w = w[2]; tap_c = coef[2]; end
         3'd3: begin tap_w = w[3]; tap_c = coef[3]; end
         3'd4: begin tap_w = w[4]; tap_c = coef[4]; end
         default: ;
      endcase
   end

   assign prod    = tap_w * tap_c;
   assign acc_nxt = acc + {{(AccSize-ProdSize){prod[ProdSize-1]}}, prod};
   assign scaled  = acc_nxt >>> Shift;

   // Clip the scaled final sum into the signed result range.
   always_comb begin
      sat_res = scaled[DataSize-1:0];
      sat_nxt = 1'b0;
      if (scaled > SatMax) begin
         sat_res = {1'b0, {(DataSize-1){1'b1}}};
         sat_nxt = 1'b1;
      end else if (scaled < SatMin) begin
         sat_res = {1'b1, {(DataSize-1){1'b0}}};
         sat_nxt = 1'b1;
      end
   end

   // Datapath: window capture, accumulation and result registration.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt      <= '0;
         acc      <= '0;
         result_q <= '0;
         sat_q    <= 1'b0;
         for (int i = 0; i < 5; i++) w[i] <= '0;
      end else begin
         case (state)
            IDLE: if (bus.start) begin
               w[0] <= bus.src1;
               w[1] <= bus.src2;
               w[2] <= bus.src3;
               w[3] <= bus.src4;
               w[4] <= bus.src5;
               acc  <= '0;
               cnt  <= '0;
            end
            MAC: begin
               acc <= acc_nxt;
               cnt <= cnt + 3'd1;
               if (cnt == 3'd4) begin
                  result_q <= sat_res;
                  sat_q    <= sat_nxt;
               end
            end
            default: ;
         endcase
      end
   end

   // Coefficient bank: writable only while idle, out-of-range indices dropped.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 5; i++) coef[i] <= '0;
      end else if (bus.coef_wr && state == IDLE) begin
         case (bus.coef_addr)
            3'd0: coef[0] <= bus.coef_data;
            3'd1: coef[1] <= bus.coef_data;
            3'd2: coef[2] <= bus.coef_data;
            3'd3: coef[3] <= bus.coef_data;
            3'd4: coef[4] <= bus.coef_data;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_conv5_mac.sv
// Directed bench for conv5_mac; a second instance with Shift=2 shares inputs.
module tb_conv5_mac;
   logic clk, rst;
   int   checks, failures;

   conv5_mac_if #(.DataSize(32), .CoefSize(16)) bus_a ();
   conv5_mac_if #(.DataSize(32), .CoefSize(16)) bus_b ();

   assign bus_b.start     = bus_a.start;
   assign bus_b.src1      = bus_a.src1;
   assign bus_b.src2      = bus_a.src2;
   assign bus_b.src3      = bus_a.src3;
   assign bus_b.src4      = bus_a.src4;
   assign bus_b.src5      = bus_a.src5;
   assign bus_b.coef_wr   = bus_a.coef_wr;
   assign bus_b.coef_addr = bus_a.coef_addr;
   assign bus_b.coef_data = bus_a.coef_data;

   conv5_mac #(.DataSize(32), .CoefSize(16), .Shift(0)) u_dut  (.clk(clk), .rst(rst), .bus(bus_a));
   conv5_mac #(.DataSize(32), .CoefSize(16), .Shift(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_coefs(input logic [15:0] c0, c1, c2, c3, c4);
      logic [15:0] c [5];
      c = '{c0, c1, c2, c3, c4};
      for (int i = 0; i < 5; i++) begin
         bus_a.coef_wr = 1'b1; bus_a.coef_addr = 3'(i); bus_a.coef_data = c[i];
         tick;
      end
      bus_a.coef_wr = 1'b0;
   endtask

   task automatic set_src(input logic [31:0] s1, s2, s3, s4, s5);
      bus_a.src1 = s1; bus_a.src2 = s2; bus_a.src3 = s3; bus_a.src4 = s4; bus_a.src5 = s5;
   endtask

   // Run one operation; returns latency (edges after the start edge) and outputs.
   task automatic do_run(output int lat, output logic [31:0] res, output logic s,
                         output logic [31:0] res2, output logic busy_run,
                         output logic ov_after, output logic busy_after);
      bus_a.start = 1'b1;
      tick;
      bus_a.start = 1'b0; bus_a.coef_wr = 1'b0;
      busy_run = bus_a.busy;
      lat = 0;
      while (bus_a.out_valid !== 1'b1 && lat < 20) begin tick; lat++; end
      res = bus_a.result; s = bus_a.sat; res2 = bus_b.result;
      tick;
      ov_after = bus_a.out_valid; busy_after = bus_a.busy;
   endtask

   task automatic test_reset;
      rst = 1'b0;
      bus_a.start = 0; bus_a.coef_wr = 0; bus_a.coef_addr = 0; bus_a.coef_data = 0;
      set_src(0, 0, 0, 0, 0);
      #1;
      checks++; if (bus_a.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", bus_a.busy); end
      checks++; if (bus_a.out_valid !== 1'b0) begin failures++; $display("FAIL reset_ov got=%0b exp=0", bus_a.out_valid); end
      checks++; if (bus_a.result !== 32'd0) begin failures++; $display("FAIL reset_result got=%0h exp=0", bus_a.result); end
      checks++; if (bus_a.sat !== 1'b0) begin failures++; $display("FAIL reset_sat got=%0b exp=0", bus_a.sat); end
      tick; tick;
      rst = 1'b1;
      tick;
   endtask

   task automatic test_basic;
      int lat; logic [31:0] r, r2; logic s, b, ova, ba;
      set_coefs(1, 2, 3, 4, 5);
      set_src(10, 20, 30, 40, 50);
      do_run(lat, r, s, r2, b, ova, ba);
      checks++; if (b !== 1'b1) begin failures++; $display("FAIL basic_busy_after_start got=%0b exp=1", b); end
      checks++; if (lat != 5) begin failures++; $display("FAIL basic_latency got=%0d exp=5", lat); end
      checks++; if (r !== 32'd550) begin failures++; $display("FAIL basic_result got=%0d exp=550", r); end
      checks++; if (s !== 1'b0) begin failures++; $display("FAIL basic_sat got=%0b exp=0", s); end
      checks++; if (ova !== 1'b0) begin failures++; $display("FAIL basic_single_pulse got=%0b exp=0", ova); end
      checks++; if (ba !== 1'b0) begin failures++; $display("FAIL basic_busy_drop got=%0b exp=0", ba); end
   endtask

   task automatic test_reset_midrun;
      int lat; logic [31:0] r, r2; logic s, b, ova, ba;
      set_src(10, 20, 30, 40, 50);
      bus_a.start = 1'b1; tick; bus_a.start = 1'b0;
      tick; tick;
      #2; rst = 1'b0; #1;
      checks++; if (bus_a.busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%0b exp=0", bus_a.busy); end
      checks++; if (bus_a.out_valid !== 1'b0) begin failures++; $display("FAIL midrst_ov got=%0b exp=0", bus_a.out_valid); end
      checks++; if (bus_a.result !== 32'd0) begin failures++; $display("FAIL midrst_result got=%0h exp=0", bus_a.result); end
      checks++; if (bus_a.sat !== 1'b0) begin failures++; $display("FAIL midrst_sat got=%0b exp=0", bus_a.sat); end
      tick; tick;
      rst = 1'b1;
      tick;
      do_run(lat, r, s, r2, b, ova, ba);
      checks++; if (lat != 5) begin failures++; $display("FAIL midrst_rerun_latency got=%0d exp=5", lat); end
      checks++; if (r !== 32'd0) begin failures++; $display("FAIL midrst_zero_coef got=%0d exp=0", r); end
   endtask

   task automatic test_signed_shift;
      int lat; logic [31:0] r, r2; logic s, b, ova, ba;
      set_coefs(16'hFFFF, 0, 0, 0, 0);
      set_src(32'hFFFF_FFFF, 7, 7, 7, 7);
      do_run(lat, r, s, r2, b, ova, ba);
      checks++; if (r !== 32'd1) begin failures++; $display("FAIL signed_neg_neg got=%0h exp=1", r); end
      checks++; if (r2 !== 32'd0) begin failures++; $display("FAIL signed_shift2_one got=%0h exp=0", r2); end
      set_src(5, 0, 0, 0, 0);
      do_run(lat, r, s, r2, b, ova, ba);
      checks++; if (r !== 32'hFFFF_FFFB) begin failures++; $display("FAIL signed_neg_result got=%0h exp=fffffffb", r); end
      checks++; if (r2 !== 32'hFFFF_FFFE) begin failures++; $display("FAIL shift_arith_neg got=%0h exp=fffffffe", r2); end
      set_coefs(4, 4, 4, 4, 4);
      set_src(3, 3, 3, 3, 3);
      do_run(lat, r, s, r2, b, ova, ba);
      checks++; if (r !== 32'd60) begin failures++; $display("FAIL shift0_sum got=%0d exp=60", r); end
      checks++; if (r2 !== 32'd15) begin failures++; $display("FAIL shift2_sum got=%0d exp=15", r2); end
   endtask

   task automatic test_saturation;
      int lat; logic [31:0] r, r2; logic s, b, ova, ba;
      set_coefs(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
      set_src(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
      do_run(lat, r, s, r2, b, ova, ba);
      checks++; if (r !== 32'h7FFF_FFFF || s !== 1'b1) begin failures++; $display("FAIL sat_pos got=%0h/%0b exp=7fffffff/1", r, s); end
      set_coefs(16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000);
      do_run(lat, r, s, r2, b, ova, ba);
      checks++; if (r !== 32'h8000_0000 || s !== 1'b1) begin failures++; $display("FAIL sat_neg got=%0h/%0b exp=80000000/1", r, s); end
      set_coefs(1, 1, 0, 0, 0);
      set_src(32'h7FFF_FFFF, 0, 0, 0, 0);
      do_run(lat, r, s, r2, b, ova, ba);
      checks++; if (r !== 32'h7FFF_FFFF || s !== 1'b0) begin failures++; $display("FAIL sat_edge_max got=%0h/%0b exp=7fffffff/0", r, s); end
      set_src(32'h8000_0000, 0, 0, 0, 0);
      do_run(lat, r, s, r2, b, ova, ba);
      checks++; if (r !== 32'h8000_0000 || s !== 1'b0) begin failures++; $display("FAIL sat_edge_min got=%0h/%0b exp=80000000/0", r, s); end
      set_src(32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
      do_run(lat, r, s, r2, b, ova, ba);
      checks++; if (r !== 32'h8000_0000 || s !== 1'b1) begin failures++; $display("FAIL sat_below_min got=%0h/%0b exp=80000000/1", r, s); end
      set_coefs(1, 2, 3, 4, 5);
      set_src(10, 20, 30, 40, 50);
      do_run(lat, r, s, r2, b, ova, ba);
      checks++; if (r !== 32'd550 || s !== 1'b0) begin failures++; $display("FAIL sat_clear got=%0d/%0b exp=550/0", r, s); end
      tick; tick; tick;
      checks++; if (bus_a.result !== 32'd550 || bus_a.out_valid !== 1'b0) begin failures++; $display("FAIL result_hold got=%0d/%0b exp=550/0", bus_a.result, bus_a.out_valid); end
   endtask

   task automatic test_isolation;
      int lat, extra; logic [31:0] r, r2; logic s, b, ova, ba;
      set_src(10, 20, 30, 40, 50);
      bus_a.start = 1'b1; tick; bus_a.start = 1'b0;
      set_src(0, 0, 0, 0, 0);
      bus_a.coef_wr = 1'b1; bus_a.coef_addr = 0; bus_a.coef_data = 100;
      tick;
      bus_a.coef_wr = 1'b0; bus_a.start = 1'b1;
      tick;
      bus_a.start = 1'b0;
      lat = 2;
      while (bus_a.out_valid !== 1'b1 && lat < 20) begin tick; lat++; end
      checks++; if (lat != 5) begin failures++; $display("FAIL iso_latency got=%0d exp=5", lat); end
      checks++; if (bus_a.result !== 32'd550) begin failures++; $display("FAIL iso_result got=%0d exp=550", bus_a.result); end
      extra = 0;
      for (int i = 0; i < 8; i++) begin
         tick;
         if (bus_a.out_valid === 1'b1 || bus_a.busy === 1'b1) extra++;
      end
      checks++; if (extra != 0) begin failures++; $display("FAIL iso_start_not_queued got=%0d exp=0", extra); end
      set_src(10, 20, 30, 40, 50);
      bus_a.coef_wr = 1'b1; bus_a.coef_addr = 6; bus_a.coef_data = 100;
      tick;
      bus_a.coef_wr = 1'b0;
      do_run(lat, r, s, r2, b, ova, ba);
      checks++; if (r !== 32'd550) begin failures++; $display("FAIL iso_addr6_ignored got=%0d exp=550", r); end
      bus_a.coef_wr = 1'b1; bus_a.coef_addr = 0; bus_a.coef_data = 11;
      do_run(lat, r, s, r2, b, ova, ba);
      checks++; if (r !== 32'd650) begin failures++; $display("FAIL coef_wr_with_start got=%0d exp=650", r); end
      set_coefs(1, 2, 3, 4, 5);
   endtask

   task automatic test_back_to_back;
      int pulses, last, guard;
      set_src(10, 20, 30, 40, 50);
      pulses = 0; last = -1;
      bus_a.start = 1'b1;
      for (int i = 0; i < 30; i++) begin
         tick;
         if (bus_a.out_valid === 1'b1) begin
            checks++; if (bus_a.result !== 32'd550) begin failures++; $display("FAIL b2b_result got=%0d exp=550", bus_a.result); end
            if (pulses == 0) begin
               checks++; if (i != 5) begin failures++; $display("FAIL b2b_first_pulse got=%0d exp=5", i); end
            end else begin
               checks++; if (i - last != 7) begin failures++; $display("FAIL b2b_spacing got=%0d exp=7", i - last); end
            end
            last = i;
            pulses++;
         end
      end
      bus_a.start = 1'b0;
      checks++; if (pulses != 4) begin failures++; $display("FAIL b2b_pulse_count got=%0d exp=4", pulses); end
      guard = 0;
      while (bus_a.busy === 1'b1 && guard < 20) begin tick; guard++; end
      checks++; if (bus_a.busy !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%0b exp=0", bus_a.busy); end
   endtask

   initial begin
      checks = 0; failures = 0;
      test_reset;
      test_basic;
      test_reset_midrun;
      test_signed_shift;
      test_saturation;
      test_isolation;
      test_back_to_back;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
